mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 64-bit in-order pipeline. It sits directly downstream of the EX/MEM pipeline registers and consumes their outputs: ALU result, store data, destination register, memory/writeback control, and the branch target/decision. It drives a valid/ready data-memory port, sizes and aligns loads and stores, stalls upstream while an access is outstanding, and registers its results toward writeback.

## Interface
- DATA_WIDTH, 64, datapath width; only 64 is supported.
- REG_ID_WIDTH, 5, register ID width.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  EX/MEM holds a live instruction.
- alu_res_in  in  DATA_WIDTH  effective address, or the result for non-memory ops.
- write_data_in  in  DATA_WIDTH  store data, right-aligned.
- funct3_in  in  3  access size and sign; RISC-V load/store encoding.
- mem_control_in  in  3  {branch, mem_read, mem_write}.
- wb_control_in  in  2  {reg_write, mem_to_reg}.
- dest_in  in  REG_ID_WIDTH  destination register.
- target_in  in  DATA_WIDTH  branch target.
- branch_decision_in  in  1  ALU branch-taken decision.
- stall_out  out  1  holds EX/MEM and earlier stages.
- req_valid, req_ready  out/in  1  memory request handshake.
- req_addr  out  DATA_WIDTH  8-byte-aligned address ({addr[63:3],3'b0}).
- req_we  out  1  1 = store.
- req_wdata  out  DATA_WIDTH  lane-shifted store data.
- req_wstrb  out  8  byte enables.
- resp_valid  in  1  response; carries load data or the store acknowledge.
- resp_rdata  in  DATA_WIDTH  aligned 64-bit read word.
- valid_out  out  1  result valid toward MEM/WB.
- mem_data_out, alu_res_out  out  DATA_WIDTH  load result; passed-through ALU result.
- dest_out  out  REG_ID_WIDTH; wb_control_out  out  2.
- pc_src_out  out  1  taken-branch redirect; target_out  out  DATA_WIDTH.
- misaligned_out  out  1  one-cycle misaligned-access flag.

## Operation
- FSM states: IDLE, REQ, WAIT. An instruction is consumed only in IDLE.
- IDLE, valid_in=1, no mem op:
  - Next cycle: valid_out=1 with alu_res, dest and wb_control.
  - pc_src_out = branch & branch_decision_in; target_out = target_in.
- IDLE, mem op (mem_read|mem_write):
  - Alignment rules: half-word needs addr[0]=0; word needs addr[1:0]=0; double-word needs addr[2:0]=0.
  - Aligned: latch address, data, funct3 and control; go to REQ.
  - Misaligned: no request is issued. Next cycle valid_out=1, wb_control_out[1] forced to 0, misaligned_out=1.
- REQ:
  - req_valid=1, with request fields stable.
  - On req_ready=1, go to WAIT. A request is issued exactly once per access.
- WAIT:
  - On resp_valid=1, go to IDLE. Next cycle valid_out=1, with mem_data_out = extracted load data (0 for a store).
- Store data path:
  - lane = addr[2:0].
  - req_wdata = write_data << 8*lane.
  - req_wstrb = {01,03,0F,FF}[size] << lane.
- Load data path:
  - Select resp_rdata[8*lane +: size].
  - funct3 000/001/010 sign-extend; 100/101/110 zero-extend; 011 is the full 64 bits.
  - Load funct3 111 is treated as 011.
- mem_read and mem_write both set: mem_write wins and the access is a store.
- Handshake signals are ignored while they have no meaning:
  - resp_valid in IDLE or REQ is ignored.
  - req_ready outside REQ is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - All registered outputs are 0, including valid_out, pc_src_out and misaligned_out.
  - req_valid = 0 in the cycle after the reset edge.
- stall_out = (state != IDLE), combinational.
  - The instruction that follows a memory op is held through REQ and WAIT.
  - It is consumed in the first IDLE cycle, which costs one bubble.
- Outputs are registered: a non-memory op appears 1 cycle after acceptance.
- Memory-op latency:
  - valid_out rises 1 cycle after the cycle in which resp_valid is sampled.
  - Minimum latency is 3 cycles from acceptance: ready and response both on their first opportunity.
- valid_out and misaligned_out are single-cycle pulses per instruction. valid_out=0 in any cycle without a retiring result.
- Reset in REQ or WAIT abandons the access:
  - No valid_out is produced.
  - A late resp_valid that arrives after the reset is ignored.

## Test plan
- ALU op: valid_in=1, alu_res=0x1234, dest=7, wb=10 -> next cycle valid_out=1, alu_res_out=0x1234, dest_out=7, stall_out=0 throughout.
- Load byte:
  - Stimulus: lb from 0x1003; resp_rdata=0x00000000_80000000; req_ready held 2 cycles late.
  - Required response: req_addr=0x1000, single request; mem_data_out=0xFFFF_FFFF_FFFF_FF80.
  - Required stall: stall_out high in REQ and WAIT.
- Store half-word: sh 0xBEEF to 0x2006 -> req_we=1, req_wstrb=0xC0, req_wdata=0xBEEF<<48; valid_out after the resp_valid ack, mem_data_out=0.
- Misaligned: lw at 0x3002 -> no req_valid; next cycle valid_out=1, misaligned_out=1, wb_control_out[1]=0.
- Branch: branch=1, decision=1, target=0x8000 -> next cycle pc_src_out=1, target_out=0x8000. With decision=0, pc_src_out=0.
- Reset in WAIT -> next cycle state IDLE, stall_out=0, req_valid=0, valid_out=0; a subsequent resp_valid pulse produces no valid_out.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; EX/MEM in, valid/ready data-memory port with sized/aligned access, stall_out, registered MEM/WB results out
module mem_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   alu_res_in,
  input  logic [DATA_WIDTH-1:0]   write_data_in,
  input  logic [2:0]              funct3_in,
  input  logic [2:0]              mem_control_in,
  input  logic [1:0]              wb_control_in,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  input  logic [DATA_WIDTH-1:0]   target_in,
  input  logic                    branch_decision_in,
  output logic                    stall_out,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [DATA_WIDTH-1:0]   req_addr,
  output logic                    req_we,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [7:0]              req_wstrb,
  input  logic                    resp_valid,
  input  logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic [DATA_WIDTH-1:0]   alu_res_out,
  output logic [REG_ID_WIDTH-1:0] dest_out,
  output logic [1:0]              wb_control_out,
  output logic                    pc_src_out,
  output logic [DATA_WIDTH-1:0]   target_out,
  output logic                    misaligned_out
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, shifted, load_data;
  logic [REG_ID_WIDTH-1:0] dest_q;
  logic [2:0] funct3_q;
  logic [1:0] wb_q, size;
  logic we_q, accept, mem_op, misaligned;
  assign accept = state == IDLE && valid_in;
  assign mem_op = mem_control_in[1] | mem_control_in[0];
  assign size = funct3_in[1:0];
  assign misaligned = (size == 2'd1 && alu_res_in[0]) || (size == 2'd2 && |alu_res_in[1:0]) ||
                      (size == 2'd3 && |alu_res_in[2:0]);
  assign shifted = resp_rdata >> {addr_q[2:0], 3'b000};
  assign load_data = funct3_q == 3'b000 ? {{56{shifted[7]}}, shifted[7:0]} :
                     funct3_q == 3'b001 ? {{48{shifted[15]}}, shifted[15:0]} :
                     funct3_q == 3'b010 ? {{32{shifted[31]}}, shifted[31:0]} :
                     funct3_q == 3'b100 ? {56'd0, shifted[7:0]} :
                     funct3_q == 3'b101 ? {48'd0, shifted[15:0]} :
                     funct3_q == 3'b110 ? {32'd0, shifted[31:0]} : shifted;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      dest_q <= '0;
      funct3_q <= '0;
      wb_q <= '0;
      we_q <= 1'b0;
      valid_out <= 1'b0;
      mem_data_out <= '0;
      alu_res_out <= '0;
      dest_out <= '0;
      wb_control_out <= '0;
      pc_src_out <= 1'b0;
      target_out <= '0;
      misaligned_out <= 1'b0;
    end else begin
      state <= state_nx;
      valid_out <= 1'b0;
      pc_src_out <= 1'b0;
      misaligned_out <= 1'b0;
      if (accept && mem_op && !misaligned) begin
        addr_q <= alu_res_in;
        wdata_q <= write_data_in;
        funct3_q <= funct3_in;
        we_q <= mem_control_in[0];
        wb_q <= wb_control_in;
        dest_q <= dest_in;
      end else if (accept) begin
        valid_out <= 1'b1;
        mem_data_out <= '0;
        alu_res_out <= alu_res_in;
        dest_out <= dest_in;
        wb_control_out <= {wb_control_in[1] & ~mem_op, wb_control_in[0]};
        pc_src_out <= mem_control_in[2] & branch_decision_in & ~mem_op;
        target_out <= target_in;
        misaligned_out <= mem_op;
      end
      if (state == WAIT && resp_valid) begin
        valid_out <= 1'b1;
        mem_data_out <= we_q ? '0 : load_data;
        alu_res_out <= addr_q;
        dest_out <= dest_q;
        wb_control_out <= wb_q;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? ((accept && mem_op && !misaligned) ? REQ : IDLE) :
               state == REQ  ? (req_ready ? WAIT : REQ) :
                               (resp_valid ? IDLE : WAIT);
  end
  always_comb begin
    stall_out = state != IDLE;
    req_valid = state == REQ;
    req_addr = {addr_q[DATA_WIDTH-1:3], 3'b000};
    req_we = we_q;
    req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    req_wstrb = (funct3_q[1:0] == 2'd0 ? 8'h01 : funct3_q[1:0] == 2'd1 ? 8'h03 :
                 funct3_q[1:0] == 2'd2 ? 8'h0F : 8'hFF) << addr_q[2:0];
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a byte-level reference model
module tb_mem_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic valid_in = 1'b0, branch_decision_in = 1'b0, req_ready = 1'b0, resp_valid = 1'b0;
  logic [63:0] alu_res_in = '0, write_data_in = '0, target_in = '0, resp_rdata = '0;
  logic [2:0] funct3_in = '0, mem_control_in = '0;
  logic [1:0] wb_control_in = '0;
  logic [4:0] dest_in = '0;
  logic stall_out, req_valid, req_we, valid_out, pc_src_out, misaligned_out;
  logic [63:0] req_addr, req_wdata, mem_data_out, alu_res_out, target_out;
  logic [7:0] req_wstrb;
  logic [4:0] dest_out;
  logic [1:0] wb_control_out;
  int n_checks = 0, n_errors = 0;
  mem_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_res_in(alu_res_in),
    .write_data_in(write_data_in), .funct3_in(funct3_in), .mem_control_in(mem_control_in),
    .wb_control_in(wb_control_in), .dest_in(dest_in), .target_in(target_in),
    .branch_decision_in(branch_decision_in), .stall_out(stall_out), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .valid_out(valid_out), .mem_data_out(mem_data_out), .alu_res_out(alu_res_out),
    .dest_out(dest_out), .wb_control_out(wb_control_out), .pc_src_out(pc_src_out),
    .target_out(target_out), .misaligned_out(misaligned_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd3 ? 8 : (1 << f3[1:0]);
  endfunction
  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd);
    int nb = nbytes(f3);
    logic [63:0] v = rd >> (8 * a[2:0]);
    logic [63:0] m = nb == 8 ? '1 : (64'd1 << (8 * nb)) - 64'd1;
    v &= m;
    if (!f3[2] && nb < 8 && v[8*nb-1]) v |= ~m;
    return v;
  endfunction
  task automatic scramble();
    alu_res_in = {$urandom, $urandom};
    write_data_in = {$urandom, $urandom};
    target_in = {$urandom, $urandom};
    funct3_in = 3'($urandom);
    mem_control_in = 3'($urandom);
    wb_control_in = 2'($urandom);
    dest_in = 5'($urandom);
    branch_decision_in = 1'($urandom);
  endtask
  task automatic exec(input logic [2:0] mc, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input logic [1:0] wb, input logic [4:0] d,
                      input logic [63:0] tg, input logic bd, input int rdly, input int sdly,
                      input logic [63:0] rd);
    int nb = nbytes(f3);
    logic mem = mc[1] | mc[0];
    logic st = mc[0];
    logic mis = mem && (a % 64'(nb) != 64'd0);
    @(negedge clk);
    check("idle_stall", stall_out, 0);
    check("idle_valid", valid_out, 0);
    valid_in = 1'b1; alu_res_in = a; write_data_in = wd; funct3_in = f3; mem_control_in = mc;
    wb_control_in = wb; dest_in = d; target_in = tg; branch_decision_in = bd;
    @(negedge clk);
    valid_in = 1'b0;
    scramble();
    if (!mem || mis) begin
      check("ret_valid", valid_out, 1);
      check("ret_alu", alu_res_out, a);
      check("ret_dest", dest_out, d);
      check("ret_wb", wb_control_out, {wb[1] & ~mis, wb[0]});
      check("ret_pc_src", pc_src_out, mc[2] & bd & ~mem);
      check("ret_target", target_out, tg);
      check("ret_misaligned", misaligned_out, mis);
      check("ret_memdata", mem_data_out, 0);
      check("ret_stall", stall_out, 0);
      check("ret_noreq", req_valid, 0);
    end else begin
      for (int i = 0; i < rdly; i++) begin
        check("req_hold", req_valid, 1);
        check("req_stall", stall_out, 1);
        check("req_novalid", valid_out, 0);
        resp_valid = 1'($urandom);
        @(negedge clk);
      end
      resp_valid = 1'b0;
      check("req_valid", req_valid, 1);
      check("req_stall", stall_out, 1);
      check("req_addr", req_addr, {a[63:3], 3'b000});
      check("req_we", req_we, st);
      if (st) begin
        check("req_wdata", req_wdata, wd << (8 * a[2:0]));
        check("req_wstrb", req_wstrb, 64'(((1 << nb) - 1) << a[2:0]));
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      for (int i = 0; i < sdly; i++) begin
        check("wait_noreq", req_valid, 0);
        check("wait_novalid", valid_out, 0);
        req_ready = 1'($urandom);
        @(negedge clk);
      end
      req_ready = 1'b0;
      check("wait_noreq", req_valid, 0);
      check("wait_stall", stall_out, 1);
      resp_valid = 1'b1; resp_rdata = rd;
      @(negedge clk);
      resp_valid = 1'b0; resp_rdata = {$urandom, $urandom};
      check("mem_valid", valid_out, 1);
      check("mem_data", mem_data_out, st ? 64'd0 : exp_load(f3, a, rd));
      check("mem_alu", alu_res_out, a);
      check("mem_dest", dest_out, d);
      check("mem_wb", wb_control_out, wb);
      check("mem_misaligned", misaligned_out, 0);
      check("mem_pc_src", pc_src_out, 0);
      check("mem_stall", stall_out, 0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", valid_out, 0);
    check("rst_pc_src", pc_src_out, 0);
    check("rst_misaligned", misaligned_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_req", req_valid, 0);
    check("rst_alu", alu_res_out, 0);
    exec(3'b000, 3'b000, 64'h1234, 64'd0, 2'b10, 5'd7, 64'd0, 1'b0, 0, 0, 64'd0);
    exec(3'b010, 3'b000, 64'h1003, 64'd0, 2'b11, 5'd5, 64'd0, 1'b0, 2, 1, 64'h0000_0000_8000_0000);
    check("lb_value", mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    exec(3'b001, 3'b001, 64'h2006, 64'hBEEF, 2'b00, 5'd0, 64'd0, 1'b0, 0, 0, 64'd0);
    exec(3'b010, 3'b010, 64'h3002, 64'd0, 2'b11, 5'd9, 64'd0, 1'b0, 0, 0, 64'd0);
    exec(3'b100, 3'b000, 64'd0, 64'd0, 2'b00, 5'd0, 64'h8000, 1'b1, 0, 0, 64'd0);
    exec(3'b100, 3'b000, 64'd0, 64'd0, 2'b00, 5'd0, 64'h8000, 1'b0, 0, 0, 64'd0);
    @(negedge clk);
    valid_in = 1'b1; alu_res_in = 64'h4000; funct3_in = 3'b011; mem_control_in = 3'b010;
    wb_control_in = 2'b11; dest_in = 5'd3;
    @(negedge clk);
    valid_in = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("rstw_stall", stall_out, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_stall_clr", stall_out, 0);
    check("rstw_req", req_valid, 0);
    check("rstw_valid", valid_out, 0);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    check("rstw_late_resp", valid_out, 0);
    check("rstw_late_stall", stall_out, 0);
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a = {$urandom, $urandom};
      logic [2:0] f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(nbytes(f3) - 1);
      exec(3'($urandom), f3, a, {$urandom, $urandom}, 2'($urandom), 5'($urandom),
           {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
           {$urandom, $urandom});
    end
    @(negedge clk);
    check("final_valid", valid_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
